fifosync_param: RTL and testbench



---
 rtl/fifosync_param.sv | 73 +++++++
 tb/tb_fifosync_param.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fifosync_param.sv
// fifosync_param: single-clock FIFO with registered count, level flags and error pulses; FWFT read port when FIFO_FWFT_EN is defined.
module fifosync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 4,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 rvalid_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 wr_error_o,
  output logic                 rd_error_o
);
  localparam logic [PTR_WIDTH:0]   FULL_C = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   AF_C   = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0]   AE_C   = (PTR_WIDTH+1)'(AE_LEVEL);
  localparam logic [PTR_WIDTH:0]   ONE_C  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PONE_C = PTR_WIDTH'(1);
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]   count_d;
  logic                 rd_ok, wr_ok;
  // A full FIFO still accepts a write when a pop frees the slot in the same cycle.
  always_comb begin
    rd_ok   = rd_en_i && (count_o != '0);
    wr_ok   = wr_en_i && ((count_o != FULL_C) || rd_ok);
    count_d = (wr_ok && !rd_ok) ? count_o + ONE_C :
              (rd_ok && !wr_ok) ? count_o - ONE_C : count_o;
  end
  assign full_o         = count_o == FULL_C;
  assign empty_o        = count_o == '0;
  assign almost_full_o  = count_o >= AF_C;
  assign almost_empty_o = count_o <= AE_C;
  always_ff @(posedge clk_i)
    if (wr_ok) mem[wr_ptr] <= wdata_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      wr_error_o <= 1'b0;
      rd_error_o <= 1'b0;
    end else begin
      wr_ptr     <= wr_ok ? wr_ptr + PONE_C : wr_ptr;
      rd_ptr     <= rd_ok ? rd_ptr + PONE_C : rd_ptr;
      count_o    <= count_d;
      wr_error_o <= wr_en_i && !wr_ok;
      rd_error_o <= rd_en_i && !rd_ok;
    end
`ifdef FIFO_FWFT_EN
  assign rdata_o  = mem[rd_ptr];
  assign rvalid_o = !empty_o;
`else
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rdata_o  <= rd_ok ? mem[rd_ptr] : rdata_o;
      rvalid_o <= rd_ok;
    end
`endif
endmodule

// File: tb/tb_fifosync_param.sv
// tb_fifosync_param: directed plus random stimulus against a queue-based reference model of the FIFO.
module tb_fifosync_param;
  localparam int W = 8, D = 16, PW = 4, AF = 12, AE = 4;
  logic          clk, rst, wr_en, rd_en;
  logic [W-1:0]  wdata, rdata;
  logic          rvalid, full, empty, afull, aempty, wr_err, rd_err;
  logic [PW:0]   count;
  int            errors = 0, checks = 0;
  logic [W-1:0]  q[$];
  logic [W-1:0]  exp_rdata;
  logic          exp_rvalid, exp_wr_err, exp_rd_err;

  fifosync_param #(.WIDTH(W), .DEPTH(D), .PTR_WIDTH(PW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
    .rdata_o(rdata), .rvalid_o(rvalid), .full_o(full), .empty_o(empty),
    .almost_full_o(afull), .almost_empty_o(aempty), .count_o(count),
    .wr_error_o(wr_err), .rd_error_o(rd_err));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_rdata  = '0;
    exp_rvalid = 1'b0;
    exp_wr_err = 1'b0;
    exp_rd_err = 1'b0;
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("almost_full", 32'(afull), 32'(q.size() >= AF));
    chk("almost_empty", 32'(aempty), 32'(q.size() <= AE));
    chk("wr_error", 32'(wr_err), 32'(exp_wr_err));
    chk("rd_error", 32'(rd_err), 32'(exp_rd_err));
`ifdef FIFO_FWFT_EN
    chk("rvalid", 32'(rvalid), 32'(q.size() != 0));
    if (q.size() != 0) chk("rdata", 32'(rdata), 32'(q[0]));
`else
    chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
    chk("rdata", 32'(rdata), 32'(exp_rdata));
`endif
  endtask

  task automatic step(input logic we, input logic [W-1:0] wd, input logic re);
    bit r_ok, w_ok;
    wr_en = we;
    wdata = wd;
    rd_en = re;
    @(posedge clk);
    r_ok = re && q.size() > 0;
    w_ok = we && (q.size() < D || r_ok);
    if (r_ok) exp_rdata = q.pop_front();
    if (w_ok) q.push_back(wd);
    exp_rvalid = r_ok;
    exp_wr_err = we && !w_ok;
    exp_rd_err = re && !r_ok;
    #1;
    check_all();
  endtask

  initial begin
    rst = 1;
    wr_en = 0;
    rd_en = 0;
    wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 0;
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    #3 rst = 1;
    #1;
    model_reset();
    check_all();
    chk("async_rst_rdata", 32'(rdata), 32'h0);
    #2 rst = 0;
    step(0, 8'h00, 1);
    chk("rd_err_after_rst", 32'(rd_err), 32'h1);
    step(0, 8'h00, 0);
    for (int i = 0; i < D; i++) step(1, 8'(i), 0);
    chk("full_after_fill", 32'(full), 32'h1);
    step(1, 8'hEE, 0);
    chk("overflow_pulse", 32'(wr_err), 32'h1);
    step(0, 8'h00, 0);
    chk("overflow_clears", 32'(wr_err), 32'h0);
    step(1, 8'hAA, 1);
    chk("full_both_count", 32'(count), 32'(D));
    for (int i = 0; i < D; i++) step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    chk("underflow_pulse", 32'(rd_err), 32'h1);
    step(1, 8'h5A, 1);
    chk("empty_both_count", 32'(count), 32'h1);
    step(0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(i * 7 + 1), 1);
      chk("wrap_aempty", 32'(aempty), 32'h1);
    end
    for (int i = 0; i < 400; i++) begin
      int bias = (i / 100) % 2;
      step(($urandom_range(9) < 5 + bias * 3), 8'($urandom), ($urandom_range(9) < 7 - bias * 3));
    end
    while (q.size() > 0) step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
